bcd_score_keeper: RTL and testbench

- Parametrised successor of the game score counter. Counts points in packed BCD across NUM_DIGITS decimal digits, with a tick prescaler, a run/over game state machine and a retained high score.
- Drives NUM_DIGITS seven-segment digits directly.
- Sits between the game-tick source and collision detector on one side, and the HEX display pins on the other.

---
 rtl/score_pkg.sv | 26 ++
 rtl/bcd_digit_to_seg.sv | 21 ++
 rtl/bcd_score_keeper.sv | 137 +++++++++++++
 tb/tb_bcd_score_keeper.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// score_pkg: shared state encoding, BCD digit width and seven-segment codes
// for the BCD score keeper.
`default_nettype none

package score_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    OVER = 2'b10
  } state_t;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Packed table, digit 0 in [6:0] up to digit 9 in [69:63]
  localparam logic [69:0] SEG_TABLE = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

`default_nettype wire

// File: rtl/bcd_digit_to_seg.sv
// bcd_digit_to_seg: one BCD digit to active-low seven-segment code;
// non-decimal codes 10..15 are shown blank.
`default_nettype none

module bcd_digit_to_seg
  import score_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [6:0]         seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (digit <= 4'd9) begin
      seg = SEG_TABLE[int'(digit)*7 +: 7];
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_score_keeper.sv
// bcd_score_keeper: packed-BCD game score with tick prescaler, IDLE/RUN/OVER
// control, retained high score and seven-segment drive. SCORE_SATURATE_EN clamps at all-9s.
`default_nettype none

module bcd_score_keeper
  import score_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int STEP            = 1,
  parameter int TICKS_PER_POINT = 1
) (
  input  logic                      clock,
  input  logic                      aclr,
  input  logic                      start,
  input  logic                      tick,
  input  logic                      collision,
  input  logic                      show_high,
  output logic [4*NUM_DIGITS-1:0]   score_bcd,
  output logic [4*NUM_DIGITS-1:0]   high_bcd,
  output logic [7*NUM_DIGITS-1:0]   seg_out,
  output logic [1:0]                game_state,
  output logic                      new_high
);

  localparam int W = DIGIT_W * NUM_DIGITS;

  state_t       state, next_state;
  logic [7:0]   prescaler;
  logic [W-1:0] score, high, score_inc, shown;
  logic         clear_game, count_tick, end_game, tick_hit;
  logic         carry;
  logic [4:0]   dsum;

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) state <= IDLE;
    else      state <= next_state;
  end

  // Collision outranks start, which outranks tick, while a game is running
  always_comb begin
    next_state = state;
    clear_game = 1'b0;
    count_tick = 1'b0;
    end_game   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
          clear_game = 1'b1;
        end
      end
      RUN: begin
        if (collision) begin
          next_state = OVER;
          end_game   = 1'b1;
        end else if (start) begin
          clear_game = 1'b1;
        end else if (tick) begin
          count_tick = 1'b1;
        end
      end
      OVER: begin
        if (start) begin
          next_state = RUN;
          clear_game = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    score_inc = '0;
    carry     = 1'b0;
    dsum      = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dsum = {1'b0, score[i*4 +: 4]} + {4'b0000, carry} + ((i == 0) ? 5'(STEP) : 5'd0);
      if (dsum > 5'd9) begin
        score_inc[i*4 +: 4] = 4'(dsum - 5'd10);
        carry               = 1'b1;
      end else begin
        score_inc[i*4 +: 4] = dsum[3:0];
        carry               = 1'b0;
      end
    end
`ifdef SCORE_SATURATE_EN
    if (carry) score_inc = {NUM_DIGITS{4'h9}};
`endif
  end

  assign tick_hit = (prescaler == 8'(TICKS_PER_POINT - 1));

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      score     <= '0;
      high      <= '0;
      prescaler <= '0;
      new_high  <= 1'b0;
    end else begin
      if (clear_game) begin
        score     <= '0;
        prescaler <= '0;
        new_high  <= 1'b0;
      end else if (count_tick) begin
        if (tick_hit) begin
          score     <= score_inc;
          prescaler <= '0;
        end else begin
          prescaler <= prescaler + 8'd1;
        end
      end
      // Packed BCD orders the same as its decimal value
      if (end_game && (score > high)) begin
        high     <= score;
        new_high <= 1'b1;
      end
    end
  end

  assign shown = show_high ? high : score;

  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit_to_seg u_seg (
        .digit (shown[g*4 +: 4]),
        .seg   (seg_out[g*7 +: 7])
      );
    end
  endgenerate

  assign score_bcd  = score;
  assign high_bcd   = high;
  assign game_state = state;

endmodule

`default_nettype wire

// File: tb/tb_bcd_score_keeper.sv
// tb_bcd_score_keeper: directed self-checking bench for bcd_score_keeper
// (default, TICKS_PER_POINT=3 and STEP=5 instances) and the digit decoder.
`default_nettype none

module tb_bcd_score_keeper;

  logic        clock = 1'b0;
  logic        aclr  = 1'b0;
  logic [2:0]  start_v = '0, tick_v = '0, coll_v = '0, showh_v = '0;

  logic [15:0] score0, high0, score1, high1, score2, high2;
  logic [27:0] seg0, seg1, seg2;
  logic [1:0]  st0, st1, st2;
  logic        nh0, nh1, nh2;
  logic [3:0]  dec_in = '0;
  logic [6:0]  dec_out;

  int checks = 0;
  int errors = 0;

  localparam logic [27:0] SEG_0000 = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [27:0] SEG_0007 = {7'h40, 7'h40, 7'h40, 7'h78};
  localparam logic [27:0] SEG_0300 = {7'h40, 7'h30, 7'h40, 7'h40};

  always #5 clock = ~clock;

  bcd_score_keeper dut0 (
    .clock(clock), .aclr(aclr), .start(start_v[0]), .tick(tick_v[0]),
    .collision(coll_v[0]), .show_high(showh_v[0]), .score_bcd(score0),
    .high_bcd(high0), .seg_out(seg0), .game_state(st0), .new_high(nh0)
  );

  bcd_score_keeper #(.TICKS_PER_POINT(3)) dut_t3 (
    .clock(clock), .aclr(aclr), .start(start_v[1]), .tick(tick_v[1]),
    .collision(coll_v[1]), .show_high(showh_v[1]), .score_bcd(score1),
    .high_bcd(high1), .seg_out(seg1), .game_state(st1), .new_high(nh1)
  );

  bcd_score_keeper #(.STEP(5)) dut_s5 (
    .clock(clock), .aclr(aclr), .start(start_v[2]), .tick(tick_v[2]),
    .collision(coll_v[2]), .show_high(showh_v[2]), .score_bcd(score2),
    .high_bcd(high2), .seg_out(seg2), .game_state(st2), .new_high(nh2)
  );

  bcd_digit_to_seg u_dec (.digit(dec_in), .seg(dec_out));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input int id);
    start_v[id] = 1'b1;
    @(negedge clock);
    start_v[id] = 1'b0;
  endtask

  task automatic pulse_coll(input int id);
    coll_v[id] = 1'b1;
    @(negedge clock);
    coll_v[id] = 1'b0;
  endtask

  task automatic ticks(input int id, input int n);
    tick_v[id] = 1'b1;
    repeat (n) @(negedge clock);
    tick_v[id] = 1'b0;
  endtask

  logic [6:0] exp_tab [16];

  initial begin
    exp_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f};

    // Power-on reset
    #1 aclr = 1'b1;
    #1;
    check("rst_state", st0, 2'b00);
    check("rst_score", score0, 16'h0000);
    check("rst_high", high0, 16'h0000);
    check("rst_seg", seg0, SEG_0000);
    check("rst_new_high", nh0, 1'b0);
    @(negedge clock);
    aclr = 1'b0;
    @(negedge clock);

    // IDLE ignores tick
    ticks(0, 2);
    check("idle_tick", score0, 16'h0000);

    // Prescaler of 3
    pulse_start(1);
    check("t3_run", st1, 2'b01);
    ticks(1, 9);
    check("t3_nine", score1, 16'h0003);
    ticks(1, 2);
    check("t3_eleven", score1, 16'h0003);
    tick_v[1] = 1'b1;
    #1 check("t3_pre_edge", score1, 16'h0003);
    @(negedge clock);
    tick_v[1] = 1'b0;
    check("t3_twelve", score1, 16'h0004);

    // STEP of 5 with carry ripple and overflow
    pulse_start(2);
    ticks(2, 19);
    check("s5_0095", score2, 16'h0095);
    ticks(2, 1);
    check("s5_0100", score2, 16'h0100);
    ticks(2, 1979);
    check("s5_9995", score2, 16'h9995);
    ticks(2, 1);
`ifdef SCORE_SATURATE_EN
    check("s5_overflow", score2, 16'h9999);
`else
    check("s5_overflow", score2, 16'h0000);
`endif

    // Asynchronous clear mid-game
    pulse_start(0);
    ticks(0, 42);
    check("run_0042", score0, 16'h0042);
    check("run_state", st0, 2'b01);
    #2 aclr = 1'b1;
    #1;
    check("aclr_score", score0, 16'h0000);
    check("aclr_high", high0, 16'h0000);
    check("aclr_state", st0, 2'b00);
    check("aclr_seg", seg0, SEG_0000);
    #1 aclr = 1'b0;
    @(negedge clock);

    // Game 1: new high 0120
    pulse_start(0);
    ticks(0, 120);
    pulse_coll(0);
    check("g1_state", st0, 2'b10);
    check("g1_high", high0, 16'h0120);
    check("g1_new_high", nh0, 1'b1);
    ticks(0, 3);
    check("over_frozen", score0, 16'h0120);
    pulse_coll(0);
    check("over_state", st0, 2'b10);
    check("over_nh_hold", nh0, 1'b1);

    // Game 2: equal score, no new high
    pulse_start(0);
    check("g2_nh_clr", nh0, 1'b0);
    check("g2_score_clr", score0, 16'h0000);
    check("g2_high_kept", high0, 16'h0120);
    ticks(0, 120);
    pulse_coll(0);
    check("g2_new_high", nh0, 1'b0);
    check("g2_high", high0, 16'h0120);

    // Game 3: new high 0300
    pulse_start(0);
    ticks(0, 300);
    pulse_coll(0);
    check("g3_high", high0, 16'h0300);
    check("g3_new_high", nh0, 1'b1);

    // Collision beats start and tick
    pulse_start(0);
    ticks(0, 50);
    start_v[0] = 1'b1; tick_v[0] = 1'b1; coll_v[0] = 1'b1;
    @(negedge clock);
    start_v[0] = 1'b0; tick_v[0] = 1'b0; coll_v[0] = 1'b0;
    check("combo_state", st0, 2'b10);
    check("combo_score", score0, 16'h0050);
    ticks(0, 1);
    check("combo_after_tick", score0, 16'h0050);
    check("combo_high", high0, 16'h0300);
    check("combo_nh", nh0, 1'b0);

    // Display select
    pulse_start(0);
    ticks(0, 7);
    #1 check("disp_score", seg0, SEG_0007);
    showh_v[0] = 1'b1;
    #1 check("disp_high", seg0, SEG_0300);
    showh_v[0] = 1'b0;
    #1 check("disp_back", seg0, SEG_0007);

    // Decoder including non-decimal codes
    for (int i = 0; i < 16; i++) begin
      dec_in = 4'(i);
      #1 check($sformatf("dec_%0d", i), dec_out, exp_tab[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
